physics_div_arbiter: RTL and testbench

//  Shares one serial 48-bit divider among several physics requesters (per-player x/y

---
 rtl/phys_pkg.sv | 37 +++
 rtl/phys_serial_divider.sv | 74 +++++++
 rtl/physics_div_arbiter.sv | 157 +++++++++++++++
 tb/tb_physics_div_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_pkg.sv
// Shared constants, FSM encoding and the requester pick function for the physics divider arbiter.
// PHYS_DIV_RR_EN (in the top) selects round-robin over fixed-priority arbitration.
package phys_pkg;

  localparam int PHYS_NUM_REQ = 4;
  localparam int PHYS_DVD_W   = 48;
  localparam int PHYS_DVS_W   = 32;
  localparam int PHYS_GID_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // First requester found scanning upward from 'start', wrapping at PHYS_NUM_REQ.
  function automatic logic [PHYS_GID_W-1:0] pick_winner(input logic [PHYS_NUM_REQ-1:0] req,
                                                        input logic [PHYS_GID_W-1:0] start);
    logic [PHYS_GID_W-1:0] win;
    logic [PHYS_GID_W-1:0] idx;
    logic                  found;
    win   = start;
    found = 1'b0;
    for (int k = 0; k < PHYS_NUM_REQ; k++) begin
      idx = start + PHYS_GID_W'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/phys_serial_divider.sv
// Unsigned restoring divider: one quotient bit per clock, W iterations after a start pulse.
// 'done' is high during the cycle whose closing edge performs the final iteration.
module phys_serial_divider #(
  parameter int W = 48
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [W:0]       shifted_s;

  // Load on start, otherwise shift-and-subtract while running.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    shifted_s = {rem_q, quo_q[W-1]};
    if (start) begin
      rem_d = {W{1'b0}};
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CNT_W'(W);
      run_d = 1'b1;
    end else if (run_q) begin
      // remainder stays below the divisor, so the difference always fits W bits
      if (shifted_s >= {1'b0, dvs_q}) begin
        rem_d = shifted_s[W-1:0] - dvs_q;
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted_s[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      run_d = (cnt_q != CNT_W'(1));
    end else begin
      run_d = 1'b0;
    end
  end

  // Iteration state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q <= {W{1'b0}};
      quo_q <= {W{1'b0}};
      dvs_q <= {W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done     = run_q && (cnt_q == CNT_W'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/physics_div_arbiter.sv
// Shares one serial divider among the physics requesters; signed results, one at a time.
// Define PHYS_DIV_RR_EN for round-robin arbitration; default is fixed priority (lowest index).
module physics_div_arbiter
  import phys_pkg::*;
#(
  parameter int NUM_REQ = PHYS_NUM_REQ,
  parameter int DVD_W   = PHYS_DVD_W,
  parameter int DVS_W   = PHYS_DVS_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DVD_W-1:0] dividend,
  input  logic [NUM_REQ*DVS_W-1:0] divisor,
  output logic [NUM_REQ-1:0]       ack,
  output logic [DVD_W-1:0]         quotient,
  output logic                     div_zero,
  output logic                     busy,
  output logic [PHYS_GID_W-1:0]    grant_id
);

  state_e                  state_q, state_d;
  logic [PHYS_GID_W-1:0]   grant_id_q, grant_id_d;
  logic                    sign_q, sign_d;
  logic                    dz_q, dz_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [DVD_W-1:0]        quotient_q, quotient_d;
  logic                    div_zero_q, div_zero_d;
  logic                    busy_q, busy_d;
  logic [PHYS_GID_W-1:0]   search_start_s, win_s;
  logic [DVD_W-1:0]        sel_dvd_s, dvd_mag_s, div_quo_s;
  logic [DVS_W-1:0]        sel_dvs_s;
  logic                    start_s, div_done_s;

`ifdef PHYS_DIV_RR_EN
  logic [PHYS_GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  assign search_start_s = rr_ptr_q;
`else
  assign search_start_s = {PHYS_GID_W{1'b0}};
`endif

  assign win_s = pick_winner(req, search_start_s);

  // Operands of the granted requester and the dividend magnitude (2^47 fits unsigned).
  always_comb begin
    sel_dvd_s = dividend[int'(grant_id_q)*DVD_W +: DVD_W];
    sel_dvs_s = divisor[int'(grant_id_q)*DVS_W +: DVS_W];
    dvd_mag_s = sel_dvd_s[DVD_W-1] ? ({DVD_W{1'b0}} - sel_dvd_s) : sel_dvd_s;
  end

  phys_serial_divider #(.W(DVD_W)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (start_s),
    .dividend (dvd_mag_s),
    .divisor  ({{(DVD_W-DVS_W){1'b0}}, sel_dvs_s}),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );

  // Arbitration FSM next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    sign_d     = sign_q;
    dz_d       = dz_q;
    ack_d      = {NUM_REQ{1'b0}};
    quotient_d = quotient_q;
    div_zero_d = div_zero_q;
    start_s    = 1'b0;
`ifdef PHYS_DIV_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_id_d = win_s;
`ifdef PHYS_DIV_RR_EN
          rr_ptr_d   = win_s + PHYS_GID_W'(1);
`endif
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        sign_d = sel_dvd_s[DVD_W-1];
        dz_d   = (sel_dvs_s == {DVS_W{1'b0}});
        if (sel_dvs_s == {DVS_W{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          start_s = 1'b1;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DONE: begin
        // a requester that let go of req still gets its result latched, just no ack
        ack_d[grant_id_q] = req[grant_id_q];
        if (dz_q) begin
          quotient_d = {DVD_W{1'b0}};
          div_zero_d = 1'b1;
        end else begin
          quotient_d = sign_q ? ({DVD_W{1'b0}} - div_quo_s) : div_quo_s;
          div_zero_d = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_id_q <= {PHYS_GID_W{1'b0}};
      sign_q     <= 1'b0;
      dz_q       <= 1'b0;
      ack_q      <= {NUM_REQ{1'b0}};
      quotient_q <= {DVD_W{1'b0}};
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PHYS_DIV_RR_EN
      rr_ptr_q   <= {PHYS_GID_W{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      sign_q     <= sign_d;
      dz_q       <= dz_d;
      ack_q      <= ack_d;
      quotient_q <= quotient_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
`ifdef PHYS_DIV_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign quotient = quotient_q;
  assign div_zero = div_zero_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_physics_div_arbiter.sv
// Scoreboard bench for physics_div_arbiter: per-requester job queues drive req, a monitor
// predicts each grant from the arbitration rule and checks every completed operation.
module tb_physics_div_arbiter;

  localparam int NR = 4;
  localparam int DW = 48;
  localparam int SW = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  dividend = '0;
  logic [NR*SW-1:0]  divisor = '0;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     quotient;
  logic              div_zero;
  logic              busy;
  logic [1:0]        grant_id;

  typedef struct { logic [DW-1:0] dvd; logic [SW-1:0] dvs; } job_t;
  typedef struct { int idx; logic [DW-1:0] q; logic dz; int start; } exp_t;

  job_t jobs [NR][$];
  exp_t sb [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ptr = 0;

  physics_div_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .dividend (dividend),
    .divisor  (divisor),
    .ack      (ack),
    .quotient (quotient),
    .div_zero (div_zero),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Signed division truncating toward zero; zero divisor gives 0.
  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, input logic [SW-1:0] b);
    longint sa, sbv, r;
    if (b == '0) return '0;
    sa  = longint'($signed(a));
    sbv = longint'({32'd0, b});
    r   = sa / sbv;
    return r[DW-1:0];
  endfunction

  function automatic int model_pick(input logic [NR-1:0] r, input int from);
    for (int k = 0; k < NR; k++) begin
      if (r[(from + k) % NR]) return (from + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (jobs[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_job(input int i, input logic [DW-1:0] a, input logic [SW-1:0] b);
    job_t j;
    j.dvd = a;
    j.dvs = b;
    jobs[i].push_back(j);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int  n = 0;
    bit  ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clock);
      n++;
      if (all_empty() && busy === 1'b0 && sb.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout waited=%0d cycles required idle", name, n);
    end
  endtask

  task automatic wait_busy(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (busy !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout busy=%b required 1", name, busy);
    end
  endtask

  // Requester driver: holds req with the head job's operands until its ack.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (req[i] && ack[i] && jobs[i].size() > 0) void'(jobs[i].pop_front());
        if (jobs[i].size() > 0) begin
          req[i] = 1'b1;
          dividend[i*DW +: DW] = jobs[i][0].dvd;
          divisor[i*SW +: SW]  = jobs[i][0].dvs;
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: predicts grants, pushes expectations, checks completion/ack/latency.
  initial begin
    logic          busy_p, rst_p;
    logic [NR-1:0] req_p, exp_ack;
    exp_t          e;
    int            w;
    busy_p = 1'b0;
    rst_p  = 1'b1;
    req_p  = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (rst_p) begin
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ack", 64'(ack), 64'd0);
        sb.delete();
        ptr = 0;
      end else if (!busy_p) begin
        chk("idle_grant", 64'(busy), 64'(req_p != '0));
        chk("ack_idle", 64'(ack), 64'd0);
        if (busy === 1'b1 && req_p != '0) begin
`ifdef PHYS_DIV_RR_EN
          w   = model_pick(req_p, ptr);
          ptr = (w + 1) % NR;
`else
          w   = model_pick(req_p, 0);
`endif
          chk("grant_id", 64'(grant_id), 64'(w));
          if (jobs[w].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_nojob actual=%0d required=no grant", w);
          end else begin
            e.idx   = w;
            e.q     = ref_q(jobs[w][0].dvd, jobs[w][0].dvs);
            e.dz    = (jobs[w][0].dvs == '0);
            e.start = cyc;
            sb.push_back(e);
          end
        end
      end else if (busy === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done ack=%b required no operation", ack);
        end else begin
          e = sb.pop_front();
          exp_ack = req_p[e.idx] ? (4'b0001 << e.idx) : 4'b0000;
          chk("quotient", 64'(quotient), 64'(e.q));
          chk("div_zero", 64'(div_zero), 64'(e.dz));
          chk("ack", 64'(ack), 64'(exp_ack));
          chk("latency", 64'(cyc - e.start), e.dz ? 64'd2 : 64'd50);
        end
      end else begin
        chk("ack_busy", 64'(ack), 64'd0);
      end
      busy_p = busy;
      req_p  = req;
      rst_p  = reset;
    end
  end

  // Directed scenarios followed by random batches.
  initial begin
    int   mask;
    logic [SW-1:0] b;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);

    push_job(0, 48'd1024000, 32'd10);
    wait_idle(200, "t1");
    chk("t1_quotient", 64'(quotient), 64'd102400);

    push_job(2, 48'hFFFF_FFFF_FFF9, 32'd2);
    push_job(2, 48'h8000_0000_0000, 32'd1);
    wait_idle(300, "t2");
    chk("t2_min_quotient", 64'(quotient), 64'h0000_8000_0000_0000);

    push_job(1, 48'd500, 32'd0);
    wait_idle(50, "t3");
    chk("t3_quotient", 64'(quotient), 64'd0);
    chk("t3_div_zero", 64'(div_zero), 64'd1);

    for (int i = 0; i < NR; i++) push_job(i, rand48(), $urandom_range(1, 5000));
    wait_idle(600, "t4_all");

    for (int k = 0; k < 3; k++) push_job(0, rand48(), $urandom);
    push_job(1, rand48(), $urandom_range(1, 99));
    wait_idle(600, "t4_held");

    push_job(1, rand48(), 32'd7);
    wait_busy(20, "t5_grant");
    repeat (21) @(negedge clock);
    jobs[1].delete();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    push_job(3, 48'd9, 32'd3);
    wait_idle(200, "t5");
    chk("t5_quotient", 64'(quotient), 64'd3);

    push_job(0, rand48(), $urandom_range(1, 1000));
    wait_busy(20, "t6_grant");
    push_job(1, rand48(), $urandom_range(1, 1000));
    repeat (10) @(negedge clock);
    jobs[0].delete();
    wait_idle(300, "t6");

    for (int it = 0; it < 6; it++) begin
      mask = $urandom_range(1, 15);
      for (int i = 0; i < NR; i++) begin
        if (mask[i]) begin
          b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
          push_job(i, rand48(), b);
        end
      end
      wait_idle(1500, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
